// File: rtl/dial_lock_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : dial_lock_fsm_if
//  Brief    : Signal bundle between the encoder-side driver and the dial
//             combination-lock FSM (step codes in, dial/lock status out).
//  Revision : 1.0  initial release
// ============================================================================
interface dial_lock_fsm_if #(
  parameter int POS_W = 4
);
  logic [1:0]       direction;
  logic             CLEAR;
  logic [POS_W-1:0] position;
  logic [1:0]       digit_idx;
  logic             unlocked;
  logic             alarm;
  logic             error;

  // Driver side: issues step codes and clear, observes the lock.
  modport master (
    output direction, CLEAR,
    input  position, digit_idx, unlocked, alarm, error
  );

  // Lock side: consumes step codes and clear, reports status.
  modport slave (
    input  direction, CLEAR,
    output position, digit_idx, unlocked, alarm, error
  );
endinterface
`default_nettype wire

// File: rtl/dial_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : dial_lock_fsm
//  Brief    : Virtual dial driven by quadrature step codes, checking a
//             right-left-right three-number combination. Drives unlocked
//             for OPEN_CYCLES cycles on a correct entry.
//             Optional macro DIAL_LOCK_FAIL_LIMIT_EN adds a consecutive
//             failure counter and a sticky ALARM state (exit via CLEAR/RST).
//  Revision : 1.0  initial release
// ============================================================================
module dial_lock_fsm #(
  parameter int DIAL_SIZE   = 16,
  parameter int POS_W       = 4,
  parameter int COMBO0      = 3,
  parameter int COMBO1      = 10,
  parameter int COMBO2      = 6,
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 8
) (
  input  logic          CLK,
  input  logic          RST,
  dial_lock_fsm_if.slave bus
);

  localparam int               c_open_w    = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [c_open_w-1:0] c_open_last = c_open_w'(OPEN_CYCLES - 1);
  localparam logic [POS_W-1:0] c_pos_max   = POS_W'(DIAL_SIZE - 1);
  localparam logic [POS_W-1:0] c_combo0    = POS_W'(COMBO0);
  localparam logic [POS_W-1:0] c_combo1    = POS_W'(COMBO1);
  localparam logic [POS_W-1:0] c_combo2    = POS_W'(COMBO2);

`ifdef DIAL_LOCK_FAIL_LIMIT_EN
  localparam int                  c_fail_w   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
  localparam logic [c_fail_w-1:0] c_fail_max = c_fail_w'(MAX_FAIL);
`endif

  typedef enum logic [2:0] {
    ST_D0    = 3'd0,
    ST_D1    = 3'd1,
    ST_D2    = 3'd2,
    ST_OPEN  = 3'd3
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
    ,
    ST_ALARM = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          dir_q;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [c_open_w-1:0] open_cnt_q, open_cnt_d;
  logic [1:0]          digit_q, digit_d;
  logic                unlocked_q;
  logic                error_q;
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
  logic [c_fail_w-1:0] fail_q, fail_d;
  logic                alarm_q;
`endif

  logic                w_step;
  logic                w_right;
  logic                w_left;
  logic                w_commit_fail;
  logic [POS_W-1:0]    w_pos_moved;

  // A step is a new right/left code; holding a code or 11 never steps.
  assign w_step  = ((bus.direction == 2'b01) || (bus.direction == 2'b10)) &&
                   (bus.direction != dir_q);
  assign w_right = w_step && (bus.direction == 2'b01);
  assign w_left  = w_step && (bus.direction == 2'b10);

  // Dial position after this cycle's step, wrapping at both ends.
  always_comb begin
    w_pos_moved = pos_q;
    if (w_right) begin
      w_pos_moved = (pos_q == c_pos_max) ? '0 : pos_q + 1'b1;
    end else if (w_left) begin
      w_pos_moved = (pos_q == '0) ? c_pos_max : pos_q - 1'b1;
    end
  end

  // Next-state logic; commits always compare against the pre-step position.
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    open_cnt_d    = open_cnt_q;
    w_commit_fail = 1'b0;
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
    fail_d        = fail_q;
`endif
    if (bus.CLEAR) begin
      // Administrative clear wins over any simultaneous step.
      state_d    = ST_D0;
      pos_d      = '0;
      open_cnt_d = '0;
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
      fail_d     = '0;
`endif
    end else begin
      pos_d = w_pos_moved;
      case (state_q)
        ST_D0: begin
          if (w_left) begin
            if (pos_q == c_combo0) state_d = ST_D1;
            else                   w_commit_fail = 1'b1;
          end
        end
        ST_D1: begin
          if (w_right) begin
            if (pos_q == c_combo1) state_d = ST_D2;
            else                   w_commit_fail = 1'b1;
          end
        end
        ST_D2: begin
          if (w_left) begin
            if (pos_q == c_combo2) begin
              state_d    = ST_OPEN;
              open_cnt_d = '0;
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
              fail_d     = '0;
`endif
            end else begin
              w_commit_fail = 1'b1;
            end
          end
        end
        ST_OPEN: begin
          // Steps still move the dial here but are never evaluated.
          if (open_cnt_q == c_open_last) begin
            state_d    = ST_D0;
            open_cnt_d = '0;
          end else begin
            open_cnt_d = open_cnt_q + 1'b1;
          end
        end
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
        ST_ALARM: begin
          // Dial is frozen; only CLEAR or reset leave this state.
          pos_d = pos_q;
        end
`endif
        default: begin
          state_d = ST_D0;
        end
      endcase

      if (w_commit_fail) begin
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
        fail_d  = fail_q + 1'b1;
        state_d = (fail_d == c_fail_max) ? ST_ALARM : ST_D0;
`else
        state_d = ST_D0;
`endif
      end
    end

    case (state_d)
      ST_D0:   digit_d = 2'd0;
      ST_D1:   digit_d = 2'd1;
      ST_D2:   digit_d = 2'd2;
      default: digit_d = 2'd3;
    endcase
  end

  // State, dial and registered outputs; reset returns everything to idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_D0;
      dir_q      <= 2'b00;
      pos_q      <= '0;
      open_cnt_q <= '0;
      digit_q    <= 2'd0;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= bus.direction;
      pos_q      <= pos_d;
      open_cnt_q <= open_cnt_d;
      digit_q    <= digit_d;
      unlocked_q <= (state_d == ST_OPEN);
      // Only the first cycle of an 11 run flags an error, even under CLEAR.
      error_q    <= (bus.direction == 2'b11) && (dir_q != 2'b11);
    end
  end

`ifdef DIAL_LOCK_FAIL_LIMIT_EN
  // Consecutive-failure counter and alarm flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fail_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      fail_q  <= fail_d;
      alarm_q <= (state_d == ST_ALARM);
    end
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif

  assign bus.position  = pos_q;
  assign bus.digit_idx = digit_q;
  assign bus.unlocked  = unlocked_q;
  assign bus.error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dial_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dial_lock_fsm
//  Brief    : Directed bench for dial_lock_fsm. Stimulus pushes the expected
//             post-edge outputs into a queue; a monitor pops and compares one
//             entry after every rising edge. Fields set to -1 are not checked.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dial_lock_fsm;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  dial_lock_fsm_if #(.POS_W(4)) bus ();

  dial_lock_fsm #(
    .DIAL_SIZE   (16),
    .POS_W       (4),
    .COMBO0      (3),
    .COMBO1      (10),
    .COMBO2      (6),
    .MAX_FAIL    (3),
    .OPEN_CYCLES (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           pos;
    int           dig;
    int           unl;
    int           alm;
    int           err;
    logic [127:0] name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   e_unl = 0;
  int   e_alm = 0;
  int   e_err = 0;
  logic g_rst = 1'b0;

  task automatic chk(input logic [127:0] nm, input string fld, input int act, input int want);
    if (want >= 0) begin
      n_checks++;
      if (act != want) begin
        n_errors++;
        $display("FAIL %0s.%s: got %0d, expected %0d", nm, fld, act, want);
      end
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic tick(input logic [1:0] d, input logic clr, input int p, input int g,
                      input logic [127:0] nm);
    exp_t e;
    @(negedge CLK);
    RST           = g_rst;
    bus.direction = d;
    bus.CLEAR     = clr;
    e.pos  = p;
    e.dig  = g;
    e.unl  = e_unl;
    e.alm  = e_alm;
    e.err  = e_err;
    e.name = nm;
    sb.push_back(e);
  endtask

  // A step is a code followed by idle; the dial is stable across both.
  task automatic stepc(input logic [1:0] d, input int p, input int g, input logic [127:0] nm);
    tick(d, 1'b0, p, g, nm);
    tick(2'b00, 1'b0, p, g, nm);
  endtask

  // 3 R, 9 L, 12 R, 1 L from D0 at position 0; returns one cycle into OPEN.
  task automatic enter_combo();
    for (int i = 1; i <= 3; i++)  stepc(2'b01, i, 0, "combo_r1");
    for (int i = 1; i <= 9; i++)  stepc(2'b10, (19 - i) % 16, 1, "combo_l");
    for (int i = 1; i <= 12; i++) stepc(2'b01, (10 + i) % 16, 2, "combo_r2");
    e_unl = 1;
    stepc(2'b10, 5, 3, "combo_open");
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "position",  int'(bus.position),  e.pos);
        chk(e.name, "digit_idx", int'(bus.digit_idx), e.dig);
        chk(e.name, "unlocked",  int'(bus.unlocked),  e.unl);
        chk(e.name, "alarm",     int'(bus.alarm),     e.alm);
        chk(e.name, "error",     int'(bus.error),     e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g3;
    bus.direction = 2'b00;
    bus.CLEAR     = 1'b0;

    // Reset check
    g_rst = 1'b0;
    repeat (3) tick(2'b00, 1'b0, 0, 0, "reset_hold");
    g_rst = 1'b1;
    tick(2'b00, 1'b0, 0, 0, "reset_rel");

    // Correct entry and open window
    enter_combo();
    repeat (6) tick(2'b00, 1'b0, 5, 3, "open_run");
    e_unl = 0;
    tick(2'b00, 1'b0, 5, 0, "open_end");

    // Wrap below zero, then a held right code gives exactly one step
    tick(2'b00, 1'b1, 0, 0, "wrap_clr");
    stepc(2'b10, 15, 0, "wrap_left");
    for (int k = 0; k < 10; k++) tick(2'b01, 1'b0, 0, 0, "hold_right");
    tick(2'b00, 1'b0, 0, 0, "hold_rel");
    tick(2'b00, 1'b1, 0, 0, "fail_clr0");

    // Three failed commits at position 1
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
    g3 = 3;
`else
    g3 = 0;
`endif
    for (int n = 1; n <= 3; n++) begin
      stepc(2'b01, 1, 0, "fail_r");
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
      if (n == 3) e_alm = 1;
`endif
      stepc(2'b10, 0, (n == 3) ? g3 : 0, "fail_l");
    end
`ifdef DIAL_LOCK_FAIL_LIMIT_EN
    stepc(2'b01, 0, 3, "alarm_frz");
    stepc(2'b10, 0, 3, "alarm_frz");
`else
    stepc(2'b01, 1, 0, "nolimit_r");
    stepc(2'b10, 0, 0, "nolimit_l");
`endif
    e_alm = 0;
    tick(2'b00, 1'b1, 0, 0, "fail_clr");

    // Invalid code pulses error once; CLEAR beats a simultaneous step
    stepc(2'b01, 1, 0, "inv_pre");
    e_err = 1;
    tick(2'b11, 1'b0, 1, 0, "inv_first");
    e_err = 0;
    tick(2'b11, 1'b0, 1, 0, "inv_hold");
    tick(2'b11, 1'b0, 1, 0, "inv_hold");
    tick(2'b01, 1'b1, 0, 0, "clr_vs_step");
    tick(2'b00, 1'b0, 0, 0, "clr_post");
    e_err = 1;
    tick(2'b11, 1'b1, 0, 0, "clr_err");
    e_err = 0;
    tick(2'b00, 1'b0, 0, 0, "clr_err_post");
    stepc(2'b01, 1, 0, "d0_right");
    tick(2'b00, 1'b1, 0, 0, "pre_open_clr");

    // Reset asserted on the fourth OPEN cycle
    enter_combo();
    tick(2'b00, 1'b0, 5, 3, "open2_run");
    tick(2'b00, 1'b0, 5, 3, "open2_run");
    @(posedge CLK);
    #2;
    g_rst = 1'b0;
    RST   = 1'b0;
    #1;
    chk("rst_async", "unlocked",  int'(bus.unlocked),  0);
    chk("rst_async", "position",  int'(bus.position),  0);
    chk("rst_async", "digit_idx", int'(bus.digit_idx), 0);
    chk("rst_async", "alarm",     int'(bus.alarm),     0);
    chk("rst_async", "error",     int'(bus.error),     0);
    e_unl = 0;
    tick(2'b00, 1'b0, 0, 0, "rst_hold");
    tick(2'b00, 1'b0, 0, 0, "rst_hold");
    g_rst = 1'b1;
    tick(2'b00, 1'b0, 0, 0, "rst_rel");
    stepc(2'b01, 1, 0, "rst_after");

    repeat (3) @(posedge CLK);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dial_lock_fsm.md
# dial_lock_fsm

Downstream consumer of the quadrature encoder's `direction` output. It turns encoder step codes into a virtual dial position and checks a three-number right-left-right combination, in the style of a mechanical combination lock. It drives the lock's `unlocked` and `alarm` outputs for the rest of the encoded lock machine.

## Interface
Parameters:
- `DIAL_SIZE`, 16: number of dial positions; position wraps modulo `DIAL_SIZE`.
- `POS_W`, 4: width of `position`; must satisfy 2^POS_W ≥ DIAL_SIZE.
- `COMBO0`, 3: first number, committed on the first right-to-left reversal.
- `COMBO1`, 10: second number, committed on the left-to-right reversal.
- `COMBO2`, 6: third number, committed on the final right-to-left reversal.
- `MAX_FAIL`, 3: consecutive failed entries that trigger alarm.
- `OPEN_CYCLES`, 8: clock cycles `unlocked` stays high.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`, input, 1: clock; all state on the rising edge.
- `RST`, input, 1: asynchronous active-low reset.
- `direction`, input, 2: encoder code. 00 means idle, 01 means right step, 10 means left step, 11 means invalid.
- `CLEAR`, input, 1: synchronous administrative clear.
- `position`, output, POS_W: current dial position.
- `digit_idx`, output, 2: 0, 1 or 2 while awaiting that number; 3 in OPEN or ALARM.
- `unlocked`, output, 1: high while in OPEN.
- `alarm`, output, 1: high while in ALARM.
- `error`, output, 1: one-cycle pulse when an invalid code is first seen.

## Operation
- **Code register.** `dir_q` holds the previous cycle's `direction`; reset value 00.
- **Step event.**
  - A step occurs when `direction` is 01 or 10 and differs from `dir_q`.
  - Holding a code produces exactly one step.
  - Going 01→10 directly produces one left step.
  - 11 never produces a step. It pulses `error` when `dir_q` ≠ 11.
- **Position update.**
  - Right step: pos+1, wrapping DIAL_SIZE-1→0.
  - Left step: pos-1, wrapping 0→DIAL_SIZE-1.
  - Every step moves position in every state except ALARM.
- **State machine.** States are D0, D1, D2, OPEN and ALARM. A commit is always evaluated on the pre-step position.
  - D0: right steps only move the dial. A left step commits: if pos==COMBO0, go to D1; otherwise fail.
  - D1: left steps only move the dial. A right step commits: if pos==COMBO1, go to D2; otherwise fail.
  - D2: right steps only move the dial. A left step commits: if pos==COMBO2, go to OPEN and clear fail_cnt; otherwise fail.
  - Fail: fail_cnt+1. If the new count equals MAX_FAIL, go to ALARM; otherwise go to D0. Position is kept.
  - OPEN: the cycle counter runs OPEN_CYCLES cycles, then the FSM returns to D0. Steps in OPEN move the dial but are never evaluated.
  - ALARM: steps are ignored and position is frozen. Exit only through CLEAR or RST.
- **CLEAR (any state).**
  - Next state is D0; position and fail_cnt go to 0.
  - CLEAR beats a simultaneous step; that step is discarded.
  - `error` is still generated during CLEAR.
- **Reset values.**
  - State D0.
  - position=0, digit_idx=0, fail_cnt=0.
  - unlocked=0, alarm=0, error=0.
  - dir_q=00, open counter 0.
- **Reset mid-operation** (including OPEN and ALARM) returns everything to the reset values immediately.

## Timing
- A step code present before edge k updates position, state and `digit_idx` at edge k.
- `unlocked` rises at the edge of the successful D2 commit.
- `unlocked` is high for exactly OPEN_CYCLES cycles. It falls at the edge where the state returns to D0.
- `alarm` rises at the edge of the MAX_FAIL-th failed commit.
- `error` is high for exactly the one cycle following the edge where 11 is first sampled.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- Macro: `DIAL_LOCK_FAIL_LIMIT_EN`.
- Defined:
  - fail_cnt and the ALARM state exist.
  - Behaviour is as described above.
- Undefined:
  - No fail counter and no ALARM state.
  - Every failed commit returns to D0 with position kept.
  - `alarm` is tied to 0.
  - MAX_FAIL is unused.

## Test plan
Defaults are assumed throughout. Each step is driven as a code, then 00.

1. **Reset check.** Hold RST low, then release → position=0, digit_idx=0, unlocked=0, alarm=0, error=0.
2. **Correct entry and open.** Enter 3 R, 9 L, 12 R, 1 L.
   - After the first L: digit_idx=1, position=2.
   - After the 9th L: position=10.
   - After the first R: digit_idx=2.
   - After the 12th R: position=6.
   - After the final L: unlocked=1 for 8 cycles, position=5, then digit_idx=0.
3. **Wrap and hold.** 1 L from position 0 → 15. Hold 01 for 10 cycles → exactly one right step, position 0.
4. **Fail to alarm.** From D0 at position 0, three times enter 1 R then 1 L, each committing at position 1 ≠ 3.
   - fail_cnt goes 1, 2, then alarm=1 and digit_idx=3.
   - Further steps leave position frozen.
   - CLEAR → alarm=0, position=0, digit_idx=0.
5. **Invalid code and CLEAR priority.** Drive 11 for 3 cycles → `error` high exactly 1 cycle and position unchanged. Then CLEAR and 01 in the same cycle → position=0, state D0.
6. **Reset inside OPEN.** Repeat scenario 2, then assert RST on the 4th OPEN cycle → unlocked=0 immediately and all reset values.
